vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing: horizontal/vertical pixel counters, sync pulses and display-enable.
- Drives the `DrawX`/`DrawY`/`blank` inputs of every ROM-based sprite/background renderer and the `hs`/`vs` pins of the VGA connector.
- Optionally delays sync/enable outputs so they line up with the renderers' ROM-plus-output-register pipeline.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_timing_gen_sync_delay.sv | 31 +++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing defaults, coordinate width and the sync bundle
// carried from the counters to the pins.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
        logic line_start;
        logic frame_start;
    } vga_sync_t;

    localparam vga_sync_t VGA_SYNC_RST = '{
        hs:          1'b1,
        vs:          1'b1,
        blank:       1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Fixed-depth register delay line for the sync bundle; every stage resets to
// the idle sync value so no stale pulse survives a reset.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  vga_sync_t sync_i,
    output vga_sync_t sync_o
);

    vga_sync_t stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= VGA_SYNC_RST;
            end
        end else begin
            stage_q[0] <= sync_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with registered sync/enable/line/frame strobes.
// Define VGA_SYNC_DELAY_EN to delay the strobes (not DrawX/DrawY) by SYNC_DELAY cycles.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int SYNC_DELAY = 2
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
    if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 1..4");
    end

    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so thresholds equal to 1024 still compare correctly.
    typedef logic [COORD_W:0]   coord_ext_t;

    localparam coord_t     H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t     V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t     COORD_ONE = coord_t'(1);
    localparam coord_ext_t H_VIS_END = coord_ext_t'(H_VISIBLE);
    localparam coord_ext_t HS_BEG    = coord_ext_t'(H_VISIBLE + H_FRONT);
    localparam coord_ext_t HS_END    = coord_ext_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_ext_t V_VIS_END = coord_ext_t'(V_VISIBLE);
    localparam coord_ext_t VS_BEG    = coord_ext_t'(V_VISIBLE + V_FRONT);
    localparam coord_ext_t VS_END    = coord_ext_t'(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t     hc_q, hc_d, vc_q, vc_d;
    coord_ext_t hx_d, vx_d;
    vga_sync_t  sync_q, sync_d, sync_out;

    // Strobes are decoded from next-state counters so they land with DrawX/DrawY.
    always_comb begin
        hc_d = hc_q + COORD_ONE;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + COORD_ONE;
        end
        hx_d = {1'b0, hc_d};
        vx_d = {1'b0, vc_d};

        sync_d             = VGA_SYNC_RST;
        sync_d.blank       = (hx_d < H_VIS_END) && (vx_d < V_VIS_END);
        sync_d.hs          = !((hx_d >= HS_BEG) && (hx_d < HS_END));
        sync_d.vs          = !((vx_d >= VS_BEG) && (vx_d < VS_END));
        sync_d.line_start  = (hc_d == '0);
        sync_d.frame_start = (hc_d == '0) && (vc_d == '0);
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_q   <= '0;
            vc_q   <= '0;
            sync_q <= VGA_SYNC_RST;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            sync_q <= sync_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    vga_sync_delay #(
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .clk_i   (vga_clk),
        .rst_n_i (reset_n),
        .sync_i  (sync_q),
        .sync_o  (sync_out)
    );
`else
    assign sync_out = sync_q;
`endif

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign hs          = sync_out.hs;
    assign vs          = sync_out.vs;
    assign blank       = sync_out.blank;
    assign line_start  = sync_out.line_start;
    assign frame_start = sync_out.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: default 640x480 timing plus a tiny
// 12x7 raster instance, random reset pulses, and sync width / period checks.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] dx, dy, tx, ty;
    logic       d_bl, d_hs, d_vs, d_ls, d_fs;
    logic       t_bl, t_hs, t_vs, t_ls, t_fs;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen u_def (
        .vga_clk (vga_clk), .reset_n (reset_n),
        .DrawX (dx), .DrawY (dy), .blank (d_bl), .hs (d_hs), .vs (d_vs),
        .line_start (d_ls), .frame_start (d_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
    ) u_tiny (
        .vga_clk (vga_clk), .reset_n (reset_n),
        .DrawX (tx), .DrawY (ty), .blank (t_bl), .hs (t_hs), .vs (t_vs),
        .line_start (t_ls), .frame_start (t_fs)
    );

    int checks = 0;
    int passes = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Expected outputs after n clean edges since reset: raster position is n
    // modulo the frame, strobes describe position n-DLY (idle before the first one).
    function automatic logic [24:0] exp_out(int n, int hv, int hf, int hsw, int hb,
                                            int vv, int vf, int vsw, int vb, int d);
        int   ht, vt, ft, p, m, pm, sx, sy;
        logic e_hs, e_vs, e_bl, e_ls, e_fs;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        ft = ht * vt;
        p  = n % ft;
        m  = n - d;
        e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
        if (m >= 1) begin
            pm   = m % ft;
            sx   = pm % ht;
            sy   = pm / ht;
            e_bl = (sx < hv) && (sy < vv);
            e_hs = !((sx >= hv + hf) && (sx < hv + hf + hsw));
            e_vs = !((sy >= vv + vf) && (sy < vv + vf + vsw));
            e_ls = (sx == 0);
            e_fs = (pm == 0);
        end
        return {10'(p % ht), 10'(p / ht), e_hs, e_vs, e_bl, e_ls, e_fs};
    endfunction

    logic [24:0] q_def [$];
    logic [24:0] q_tiny [$];
    int          n = 0;

    always @(posedge vga_clk) begin
        if (!reset_n) n = 0;
        else          n = n + 1;
        q_def.push_back(exp_out(n, 640, 16, 96, 48, 480, 10, 2, 33, DLY));
        q_tiny.push_back(exp_out(n, 8, 1, 2, 1, 4, 1, 1, 1, DLY));
    end

    logic meas_en = 1'b0;
    int   d_hs_run, t_hs_run, t_vs_run, d_ls_cnt, t_ls_cnt, t_fs_cnt;
    bit   d_ls_seen, t_ls_seen, t_fs_seen;

    always @(negedge vga_clk) begin
        logic [24:0] e;
        if (q_def.size() > 0) begin
            e = q_def.pop_front();
            check("def_out{x,y,hs,vs,blank,ls,fs}", {7'd0, dx, dy, d_hs, d_vs, d_bl, d_ls, d_fs}, {7'd0, e});
        end
        if (q_tiny.size() > 0) begin
            e = q_tiny.pop_front();
            check("tiny_out{x,y,hs,vs,blank,ls,fs}", {7'd0, tx, ty, t_hs, t_vs, t_bl, t_ls, t_fs}, {7'd0, e});
        end
        if (!meas_en) begin
            d_hs_run = 0; t_hs_run = 0; t_vs_run = 0;
            d_ls_cnt = 0; t_ls_cnt = 0; t_fs_cnt = 0;
            d_ls_seen = 0; t_ls_seen = 0; t_fs_seen = 0;
        end else begin
            if (!d_hs) d_hs_run++;
            else if (d_hs_run > 0) begin check("def_hs_width", d_hs_run, 96); d_hs_run = 0; end
            if (!t_hs) t_hs_run++;
            else if (t_hs_run > 0) begin check("tiny_hs_width", t_hs_run, 2); t_hs_run = 0; end
            if (!t_vs) t_vs_run++;
            else if (t_vs_run > 0) begin check("tiny_vs_width", t_vs_run, 12); t_vs_run = 0; end
            if (d_ls) begin
                if (d_ls_seen) check("def_line_period", d_ls_cnt, 800);
                d_ls_seen = 1; d_ls_cnt = 1;
            end else d_ls_cnt++;
            if (t_ls) begin
                if (t_ls_seen) check("tiny_line_period", t_ls_cnt, 12);
                t_ls_seen = 1; t_ls_cnt = 1;
            end else t_ls_cnt++;
            if (t_fs) begin
                if (t_fs_seen) check("tiny_frame_period", t_fs_cnt, 84);
                t_fs_seen = 1; t_fs_cnt = 1;
            end else t_fs_cnt++;
        end
    end

    initial begin
        bit found;
        reset_n = 1'b0;
        repeat (5) @(negedge vga_clk);
        reset_n = 1'b1;
        meas_en = 1'b1;
        repeat (1700) @(negedge vga_clk);
        meas_en = 1'b0;

        // Single-cycle reset in the middle of a line.
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge vga_clk);
            if (dx == 10'd300) found = 1;
        end
        check("find_drawx_300", {31'd0, found}, 32'd1);
        reset_n = 1'b0;
        @(negedge vga_clk);
        reset_n = 1'b1;
        repeat (10) @(negedge vga_clk);

        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(20, 1200)) @(negedge vga_clk);
            reset_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge vga_clk);
            reset_n = 1'b1;
        end
        repeat (200) @(negedge vga_clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
